// File: rtl/cla_pipe_adder.sv
// Pipelined carry-look-ahead adder/subtractor: one 4-bit CLA group per stage,
// group carry-out registered into the next stage, valid/ready stream handshake.
module cla_pipe_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int unsigned LAT = WIDTH / 4;

    if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_width_check
        $error("cla_pipe_adder: WIDTH must be a positive multiple of 4");
    end

    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Returns {carry_out, sum[3:0]} with every carry in flat sum-of-products form.
    function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic ci);
        logic [3:0] p;
        logic [3:0] g;
        logic [4:0] c;
        p    = x ^ y;
        g    = x & y;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        return {c[4], p ^ c[3:0]};
    endfunction

    for (genvar k = 0; k < LAT; k++) begin : g_stage
        localparam int unsigned DONE = 4 * (k + 1);
        localparam int unsigned PEND = WIDTH - DONE;

        logic [PEND+3:0] src_a;
        logic [PEND+3:0] src_b;
        logic            src_c;
        logic            src_v;
        logic [4:0]      grp;
        logic [DONE-1:0] sum_d;
        logic [DONE-1:0] sum_q;
        logic            v_q;
        logic            c_q;

        if (k == 0) begin : g_src
            assign src_a = a;
            assign src_b = b ^ {WIDTH{sub}};
            assign src_c = cin ^ sub;
            assign src_v = in_valid;
            assign sum_d = grp[3:0];
        end else begin : g_src
            assign src_a = g_stage[k-1].g_pend.pa_q;
            assign src_b = g_stage[k-1].g_pend.pb_q;
            assign src_c = g_stage[k-1].c_q;
            assign src_v = g_stage[k-1].v_q;
            assign sum_d = {grp[3:0], g_stage[k-1].sum_q};
        end

        assign grp = cla4(src_a[3:0], src_b[3:0], src_c);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q   <= 1'b0;
                c_q   <= 1'b0;
                sum_q <= '0;
            end else if (en) begin
                v_q   <= src_v;
                c_q   <= grp[4];
                sum_q <= sum_d;
            end
        end

        if (PEND > 0) begin : g_pend
            // Only the operand bits of groups not yet summed travel onward.
            logic [PEND-1:0] pa_q;
            logic [PEND-1:0] pb_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pa_q <= '0;
                    pb_q <= '0;
                end else if (en) begin
                    pa_q <= src_a[PEND+3:4];
                    pb_q <= src_b[PEND+3:4];
                end
            end
        end else begin : g_last
            // The top group still sees both operand MSBs, so overflow is resolved here.
            logic ovf_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (en) begin
                    ovf_q <= (src_a[3] == src_b[3]) && (grp[3] != src_a[3]);
                end
            end
        end
    end

    assign out_valid = g_stage[LAT-1].v_q;
    assign sum       = g_stage[LAT-1].sum_q;
    assign cout      = g_stage[LAT-1].c_q;
    assign ovf       = g_stage[LAT-1].g_last.ovf_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder: driver pushes model results on accept,
// an independent monitor pops and compares on every output handshake.
module tb_cla_pipe_adder;
    localparam int W   = 16;
    localparam int LAT = W / 4;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int unsigned  acc;
        int unsigned  st;
    } exp_t;

    logic         clk, rst, in_valid, in_ready, cin, sub;
    logic         out_valid, out_ready, cout, ovf;
    logic [W-1:0] a, b, sum;

    exp_t        sb[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc    = 0;
    int unsigned stalls = 0;
    int unsigned pops   = 0;
    logic        rand_ready  = 1'b0;
    logic        force_ready = 1'b1;
    logic        holding     = 1'b0;
    logic [W-1:0] hold_sum;
    logic         hold_cout, hold_ovf;

    cla_pipe_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : force_ready;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the effective operands.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input logic s);
        exp_t         r;
        logic [W-1:0] bx;
        longint       full;
        longint       sv;
        bx     = s ? ~y : y;
        full   = longint'(x) + longint'(bx) + longint'(ci ^ s);
        sv     = longint'($signed(x)) + longint'($signed(bx)) + longint'(ci ^ s);
        r.sum  = full[W-1:0];
        r.cout = full[W];
        r.ovf  = (sv > longint'(2 ** (W - 1)) - 1) || (sv < -longint'(2 ** (W - 1)));
        r.acc  = 0;
        r.st   = 0;
        return r;
    endfunction

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc, input logic ts);
        exp_t        e;
        int unsigned waited = 0;
        a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                e     = model(ta, tb_, tc, ts);
                e.acc = cyc;
                e.st  = stalls;
                sb.push_back(e);
                break;
            end
            waited++;
            if (waited > 100) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", waited);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '1;
            1:       return '0;
            2:       return W'(16'h8000);
            3:       return W'(16'h7FFF);
            default: return W'($urandom);
        endcase
    endfunction

    // Monitor: all decisions taken at the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            holding = 1'b0;
            chk("rst_out_valid", 32'(out_valid), 32'd0);
        end else begin
            chk("in_ready_rule", 32'(in_ready), 32'(!(out_valid && !out_ready)));
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got out_valid=1 sum=%0h, expected no beat", sum);
                end else begin
                    if (!holding)
                        chk("latency", cyc, sb[0].acc + LAT + (stalls - sb[0].st));
                    else begin
                        chk("hold_sum", 32'(sum), 32'(hold_sum));
                        chk("hold_cout", 32'(cout), 32'(hold_cout));
                        chk("hold_ovf", 32'(ovf), 32'(hold_ovf));
                    end
                    if (out_ready) begin
                        chk("sum", 32'(sum), 32'(sb[0].sum));
                        chk("cout", 32'(cout), 32'(sb[0].cout));
                        chk("ovf", 32'(ovf), 32'(sb[0].ovf));
                        void'(sb.pop_front());
                        pops++;
                        holding = 1'b0;
                    end else begin
                        holding   = 1'b1;
                        hold_sum  = sum;
                        hold_cout = cout;
                        hold_ovf  = ovf;
                    end
                end
            end
            if (out_valid && !out_ready) stalls++;
        end
    end

    initial begin
        int unsigned n;
        int unsigned pops_before;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_sum", 32'(sum), 32'd0);
        chk("reset_cout", 32'(cout), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        #21 rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed arithmetic corners
        send(16'h1234, 16'h4321, 1'b0, 1'b0);
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        send(16'h0005, 16'h0007, 1'b0, 1'b1);
        send(16'h8000, 16'h0001, 1'b0, 1'b1);
        send(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        idle(LAT + 2);

        // Streaming with three cycles of backpressure
        pops_before = pops;
        fork
            begin
                for (int i = 0; i < 8; i++) send(W'(i), W'(i * 3), 1'b0, 1'b0);
            end
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!out_valid && n < 50);
                chk("bp_out_seen", 32'(out_valid), 32'd1);
                force_ready = 1'b0;
                @(posedge clk);
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
                end
                force_ready = 1'b1;
                @(negedge clk);
                chk("bp_in_ready_high", 32'(in_ready), 32'd1);
            end
        join
        idle(LAT + 4);
        chk("bp_count", pops - pops_before, 32'd8);

        // Bubbles
        for (int i = 0; i < 6; i++) begin
            send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            idle(1);
        end
        idle(LAT + 2);

        // Asynchronous reset with beats in flight
        send(16'h1111, 16'h2222, 1'b0, 1'b0);
        send(16'h3333, 16'h0001, 1'b0, 1'b0);
        send(16'h0F0F, 16'h0101, 1'b0, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        chk("pre_reset_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        sb.delete();
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_sum", 32'(sum), 32'd0);
        chk("async_rst_cout", 32'(cout), 32'd0);
        chk("async_rst_ovf", 32'(ovf), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        pops_before = pops;
        send(16'h0001, 16'h0001, 1'b0, 1'b0);
        idle(LAT + 3);
        chk("post_reset_count", pops - pops_before, 32'd1);

        // Randomized traffic with random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        rand_ready  = 1'b0;
        force_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        idle(2);
        chk("drain_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
- Parametrised, pipelined carry-look-ahead adder/subtractor built from 4-bit CLA groups, one group per pipeline stage.
- Each stage computes group propagate/generate and all four internal carries in look-ahead form. The group carry-out is registered into the next stage.
- Serves as the wide arithmetic datapath primitive for lab ALU/MAC blocks. Uses a valid/ready stream handshake on both sides and delivers one result per cycle at full throughput.

Parameters:
- WIDTH, 16, operand width in bits. Must be a multiple of 4 and at least 4; otherwise elaboration fails.
- LAT (localparam), WIDTH/4, pipeline depth in cycles, equal to the number of CLA groups.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block accepts a beat this cycle
- a  input  WIDTH  operand A (unsigned or two's complement)
- b  input  WIDTH  operand B
- cin  input  1  carry/borrow-in
- sub  input  1  0 = add, 1 = subtract
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  result
- cout  output  1  carry-out of bit WIDTH-1
- ovf  output  1  signed two's-complement overflow

Behaviour:
- Arithmetic:
  - Effective operand bx = b XOR {WIDTH{sub}}.
  - Effective carry-in c0 = cin XOR sub.
  - {cout,sum} = a + bx + c0, computed modulo 2^(WIDTH+1).
  - With cin=0 and sub=1 the result is a-b. cout=1 means no borrow.
  - ovf = (a[MSB] == bx[MSB]) AND (sum[MSB] != a[MSB]).
- Group k (bits 4k+3..4k), per bit:
  - p = a^bx, g = a&bx.
  - c1..c4 use the full sum-of-products look-ahead equations with no rippling inside the group.
  - Each sum bit is p XOR its carry.
- Pipeline:
  - Stage k holds: the carry into group k+1; sum bits 0..4k+3 already produced; operand bits of groups k+1..LAT-1 still pending; MSB info for ovf; and a valid bit.
  - Stage 0 consumes a, bx and c0 directly from the input.
  - Each later stage consumes the registered carry of the previous stage.
  - Latency is LAT cycles from input acceptance to out_valid, with no stall. WIDTH=4 gives LAT=1, with a single registered stage.
- Handshake:
  - Global advance enable en = !out_valid | out_ready.
  - in_ready = en, purely combinational from out_valid and out_ready. No combinational path exists from in_valid to in_ready.
  - A beat is accepted when in_valid & in_ready.
  - When en=1, all stages shift together. A bubble, stage_valid=0, enters when in_valid=0.
  - When en=0, every stage register holds its value and the input is not accepted.
- Output:
  - out_valid, sum, cout and ovf are taken from the last stage.
  - sum, cout and ovf stay stable while out_valid=1 and out_ready=0.
- Data contents of invalid stages are don't-care. Valid bits must be correct.
- Simultaneous events: when out_ready=1 and in_valid=1 on the same cycle with a full pipeline, the output beat retires and the new beat enters in the same cycle. Throughput is 1 beat per cycle.
- Reset (rst=1, asynchronous, any time including mid-operation):
  - All stage valid bits clear immediately, so out_valid=0.
  - sum=0, cout=0, ovf=0, and all internal carries are 0.
  - In-flight beats are discarded.
  - in_ready=1 during and after reset.
  - The first accept occurs on the first rising edge after rst deasserts.
- Wrap-around: a carry out of the MSB is reported only on cout. sum wraps modulo 2^WIDTH.
- A group carry-out of 1 that propagates across every remaining group (all-propagate case) must reach cout in the same LAT latency.

Test Plan (WIDTH=16, LAT=4, out_ready=1 unless stated):
- Add: a=0x1234, b=0x4321, cin=0, sub=0, accepted at cycle T -> at T+4: out_valid=1, sum=0x5555, cout=0, ovf=0.
- Full carry chain: a=0xFFFF, b=0x0001, cin=0, add -> sum=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
- Subtract: a=0x0005, b=0x0007, sub=1, cin=0 -> sum=0xFFFE, cout=0, ovf=0. Then a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
- Throughput and backpressure: stream 8 beats with a=i, b=i*3 on consecutive cycles; drop out_ready for 3 cycles while out_valid=1 -> in_ready=0 for exactly those cycles; output held stable; all 8 results (4i) emerge in order, none lost or duplicated.
- Reset mid-stream: 3 beats in flight, assert rst asynchronously between clock edges -> out_valid=0 and sum=0 immediately. After release, a fresh beat 0x0001+0x0001 gives sum=0x0002 exactly 4 cycles after acceptance, with no stale results.
- Bubbles: alternate in_valid 1/0 -> out_valid follows the same pattern delayed by 4 cycles.
